nr_divide_normalize_8: RTL and testbench

NR_DIVIDE_NORMALIZE_8 -- requirements
Module: nr_divide_normalize_8

---
 rtl/nr_divide_normalize_8.sv | 146 ++++++++++++++
 tb/tb_nr_divide_normalize_8.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nr_divide_normalize_8.sv
// nr_divide_normalize_8: two-stage operand normalizer feeding a Newton-Raphson
// divider. S1 captures magnitudes, quotient sign and zero flags; S2 finds the
// leading-zero count of the denominator, left-justifies it and holds the result
// until the downstream core accepts it.
module nr_divide_normalize_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ne,
  input  logic [7:0] de,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] n_mag,
  output logic [7:0] d_norm,
  output logic [2:0] shift,
  output logic       neg,
  output logic       div_zero,
  output logic [7:0] dz_count
);

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  // Two's-complement magnitude; -128 wraps to 8'h80.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? W'(~x + W'(1)) : x;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_n_mag_q, s1_n_mag_d;
  logic [W-1:0]  s1_d_mag_q, s1_d_mag_d;
  logic          s1_neg_q,   s1_neg_d;
  logic          s1_dz_q,    s1_dz_d;

  logic          s2_valid_q,  s2_valid_d;
  logic [W-1:0]  s2_n_mag_q,  s2_n_mag_d;
  logic [W-1:0]  s2_d_norm_q, s2_d_norm_d;
  logic [SW-1:0] s2_shift_q,  s2_shift_d;
  logic          s2_neg_q,    s2_neg_d;
  logic          s2_dz_q,     s2_dz_d;
  logic [W-1:0]  dz_count_q,  dz_count_d;

  logic          s2_load;
  logic          s1_load;
  logic [SW-1:0] lzc;
  logic [W-1:0]  d_shifted;

  // Stage load conditions: S2 refills when empty or draining, S1 when empty or advancing.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // S1 next state: capture magnitudes, quotient sign and divide-by-zero flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_n_mag_d = s1_n_mag_q;
    s1_d_mag_d = s1_d_mag_q;
    s1_neg_d   = s1_neg_q;
    s1_dz_d    = s1_dz_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_n_mag_d = mag(ne);
        s1_d_mag_d = mag(de);
        s1_dz_d    = (de == '0);
        s1_neg_d   = (de != '0) && (ne != '0) && (ne[W-1] ^ de[W-1]);
      end
    end
  end

  // Leading-zero count of the denominator magnitude; highest set bit wins, zero gives 0.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (s1_d_mag_q[i]) lzc = SW'(int'(W) - 1 - i);
    end
    d_shifted = s1_d_mag_q << lzc;
  end

  // S2 next state: register normalized result, hold while stalled; count div-by-zero transfers.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_n_mag_d  = s2_n_mag_q;
    s2_d_norm_d = s2_d_norm_q;
    s2_shift_d  = s2_shift_q;
    s2_neg_d    = s2_neg_q;
    s2_dz_d     = s2_dz_q;
    dz_count_d  = dz_count_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_n_mag_d  = s1_n_mag_q;
        s2_d_norm_d = d_shifted;
        s2_shift_d  = lzc;
        s2_neg_d    = s1_neg_q;
        s2_dz_d     = s1_dz_q;
      end
    end
    if (s2_valid_q && out_ready && s2_dz_q && (dz_count_q != {W{1'b1}})) begin
      dz_count_d = dz_count_q + W'(1);
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_n_mag_q  <= '0;
      s1_d_mag_q  <= '0;
      s1_neg_q    <= 1'b0;
      s1_dz_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_n_mag_q  <= '0;
      s2_d_norm_q <= '0;
      s2_shift_q  <= '0;
      s2_neg_q    <= 1'b0;
      s2_dz_q     <= 1'b0;
      dz_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_n_mag_q  <= s1_n_mag_d;
      s1_d_mag_q  <= s1_d_mag_d;
      s1_neg_q    <= s1_neg_d;
      s1_dz_q     <= s1_dz_d;
      s2_valid_q  <= s2_valid_d;
      s2_n_mag_q  <= s2_n_mag_d;
      s2_d_norm_q <= s2_d_norm_d;
      s2_shift_q  <= s2_shift_d;
      s2_neg_q    <= s2_neg_d;
      s2_dz_q     <= s2_dz_d;
      dz_count_q  <= dz_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign n_mag     = s2_n_mag_q;
  assign d_norm    = s2_d_norm_q;
  assign shift     = s2_shift_q;
  assign neg       = s2_neg_q;
  assign div_zero  = s2_dz_q;
  assign dz_count  = dz_count_q;

endmodule

// File: tb/tb_nr_divide_normalize_8.sv
// Self-checking bench for nr_divide_normalize_8: directed vector table, stall,
// saturation and reset sequences, then randomized traffic against an
// arithmetic reference model and a FIFO scoreboard.
module tb_nr_divide_normalize_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ne;
  logic [7:0] de;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] n_mag;
  logic [7:0] d_norm;
  logic [2:0] shift;
  logic       neg;
  logic       div_zero;
  logic [7:0] dz_count;

  nr_divide_normalize_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ne        (ne),
    .de        (de),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_mag     (n_mag),
    .d_norm    (d_norm),
    .shift     (shift),
    .neg       (neg),
    .div_zero  (div_zero),
    .dz_count  (dz_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ne;
    logic [7:0] de;
    logic [7:0] n_mag;
    logic [7:0] d_norm;
    logic [2:0] shift;
    logic       neg;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [7:0] n_mag;
    logic [7:0] d_norm;
    logic [2:0] shift;
    logic       neg;
    logic       dz;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   model_dz = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [7:0] n, input logic [7:0] d);
    exp_t e;
    int nm;
    int dm;
    int s;
    nm = n[7] ? 256 - int'(n) : int'(n);
    dm = d[7] ? 256 - int'(d) : int'(d);
    s  = 0;
    if (dm != 0) while ((dm << s) < 128) s++;
    e.n_mag  = 8'(nm);
    e.d_norm = 8'(dm << s);
    e.shift  = 3'(s);
    e.dz     = (dm == 0);
    e.neg    = (dm != 0) && (n != 8'd0) && (n[7] != d[7]);
    e.acc    = 0;
    return e;
  endfunction

  // One clock cycle: drive, check visible state, then account for transfers.
  task automatic cycle(input logic iv, input logic [7:0] n, input logic [7:0] d,
                       input logic ordy, input logic use_v, input vec_t v,
                       output logic took);
    logic ox;
    logic exp_ov;
    exp_t e;
    in_valid  = iv;
    ne        = n;
    de        = d;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (out_valid && q.size() > 0) begin
      chk("n_mag", 32'(n_mag), 32'(q[0].n_mag));
      chk("d_norm", 32'(d_norm), 32'(q[0].d_norm));
      chk("shift", 32'(shift), 32'(q[0].shift));
      chk("neg", 32'(neg), 32'(q[0].neg));
      chk("div_zero", 32'(div_zero), 32'(q[0].dz));
    end
    chk("dz_count", 32'(dz_count), 32'(model_dz));
    ox   = out_valid && ordy;
    took = iv && in_ready;
    @(posedge clk);
    if (ox && q.size() > 0) begin
      e = q.pop_front();
      if (e.dz && model_dz < 255) model_dz++;
    end
    if (took) begin
      if (use_v) begin
        e.n_mag = v.n_mag; e.d_norm = v.d_norm; e.shift = v.shift;
        e.neg = v.neg; e.dz = v.dz;
      end else begin
        e = model(n, d);
      end
      e.acc = cyc;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    vec_t nv;
    logic took;
    nv = '{default: '0};
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, nv, took);
    chk(name, 32'(q.size()), 32'd0);
  endtask

  vec_t tbl[7];
  logic [7:0] pn[4];
  logic [7:0] pd[4];

  initial begin
    vec_t nv;
    logic took;
    int   idx;
    nv = '{default: '0};
    tbl[0] = '{8'd18,  8'd3,   8'd18,  8'hC0, 3'd6, 1'b0, 1'b0};
    tbl[1] = '{8'd21,  8'hFD,  8'd21,  8'hC0, 3'd6, 1'b1, 1'b0};
    tbl[2] = '{8'h80,  8'd1,   8'h80,  8'h80, 3'd7, 1'b1, 1'b0};
    tbl[3] = '{8'd0,   8'hFB,  8'd0,   8'hA0, 3'd5, 1'b0, 1'b0};
    tbl[4] = '{8'd7,   8'd0,   8'd7,   8'h00, 3'd0, 1'b0, 1'b1};
    tbl[5] = '{8'hFF,  8'h80,  8'd1,   8'h80, 3'd0, 1'b0, 1'b0};
    tbl[6] = '{8'd100, 8'd10,  8'd100, 8'hA0, 3'd4, 1'b0, 1'b0};
    pn = '{8'd18, 8'd21, 8'd100, 8'd5};
    pd = '{8'd3,  8'hFD, 8'd10,  8'd1};

    rst = 1'b1; in_valid = 1'b0; ne = '0; de = '0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_n_mag", 32'(n_mag), 32'd0);
    chk("rst_dz_count", 32'(dz_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, back-to-back with downstream always ready.
    foreach (tbl[i]) cycle(1'b1, tbl[i].ne, tbl[i].de, 1'b1, 1'b1, tbl[i], took);
    drain("drain_table");

    // Stall: only two pairs fit, then all four drain in order.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      int k;
      k = (idx < 4) ? idx : 0;
      cycle(idx < 4, pn[k], pd[k], 1'b0, 1'b0, nv, took);
      if (took) idx++;
    end
    chk("held_pairs", 32'(idx), 32'd2);
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      int k;
      k = (idx < 4) ? idx : 0;
      cycle(idx < 4, pn[k], pd[k], 1'b1, 1'b0, nv, took);
      if (took) idx++;
    end
    chk("stall_all_out", 32'(q.size()), 32'd0);

    // Divide-by-zero counter saturation.
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'd7, 8'd0, 1'b1, 1'b0, nv, took);
    drain("drain_dz");
    chk("dz_saturated", 32'(dz_count), 32'd255);

    // Reset with two pairs in flight under stall.
    cycle(1'b1, 8'd9, 8'd0, 1'b0, 1'b0, nv, took);
    cycle(1'b1, 8'd9, 8'd0, 1'b0, 1'b0, nv, took);
    chk("inflight", 32'(q.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_dz_count", 32'(dz_count), 32'd0);
    chk("rst_mid_div_zero", 32'(div_zero), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    model_dz = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'd18, 8'd3, 1'b1, 1'b0, nv, took);
    chk("post_rst_accept", 32'(took), 32'd1);
    drain("drain_post_rst");

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] rn;
      logic [7:0] rd;
      rn = 8'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) rn = 8'd0;
      cycle($urandom_range(0, 3) != 0, rn, rd, $urandom_range(0, 3) != 0, 1'b0, nv, took);
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
